// File: rtl/rds_pkg.sv
// Shared RDS definitions: offset words, checkword polynomial, encoder state and block index
// types, plus the single-bit step of the checkword LFSR.
package rds_pkg;

    localparam logic [9:0]  OFFSET_A   = 10'h0FC;
    localparam logic [9:0]  OFFSET_B   = 10'h198;
    localparam logic [9:0]  OFFSET_C   = 10'h168;
    localparam logic [9:0]  OFFSET_D   = 10'h1B4;
    localparam logic [10:0] RDS_POLY   = 11'h5B9;
    localparam int unsigned DATA_BITS  = 16;
    localparam int unsigned BLOCK_BITS = 26;

    typedef enum logic [1:0] {LOAD, CRC, SEND} state_t;
    typedef enum logic [1:0] {BLK_A, BLK_B, BLK_C, BLK_D} blk_t;

    function automatic logic [9:0] block_offset(input blk_t blk);
        case (blk)
            BLK_A:   return OFFSET_A;
            BLK_B:   return OFFSET_B;
            BLK_C:   return OFFSET_C;
            default: return OFFSET_D;
        endcase
    endfunction

    // One division step of data*x^10 mod g(x), data fed MSB first.
    function automatic logic [9:0] crc10_step(input logic [9:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[9];
        return {crc[8:0], 1'b0} ^ (fb ? RDS_POLY[9:0] : 10'd0);
    endfunction

endpackage

// File: rtl/rds_crc10.sv
// Serial RDS checkword generator: start consumes the first data bit, then 15 more bits follow
// on consecutive cycles while busy is high; crc holds the remainder afterwards.
module rds_crc10
    import rds_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       din,
    output logic       busy,
    output logic [9:0] crc
);

    logic [3:0] cnt_reg;
    logic [9:0] crc_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= 4'd0;
            crc_reg <= 10'd0;
        end else if (start) begin
            crc_reg <= crc10_step(10'd0, din);
            cnt_reg <= 4'(DATA_BITS - 1);
        end else if (cnt_reg != 4'd0) begin
            crc_reg <= crc10_step(crc_reg, din);
            cnt_reg <= cnt_reg - 4'd1;
        end
    end

    assign busy = (cnt_reg != 4'd0);
    assign crc  = crc_reg;

endmodule

// File: rtl/rds_group_encoder.sv
// RDS type-0A group builder and bit serialiser: forms blocks A..D, appends checkword+offset
// and hands out one bit per accepted bit_req.
module rds_group_encoder
    import rds_pkg::*;
#(
    parameter logic [15:0] AF_WORD = 16'hE0CD,
    parameter logic [3:0]  DI_BITS = 4'b0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pi,
    input  logic [4:0]  pty,
    input  logic        tp,
    input  logic        ta,
    input  logic        ms,
    output logic [2:0]  ps_addr,
    input  logic [7:0]  ps_data,
    input  logic        bit_req,
    output logic        bit_out,
    output logic        bit_valid,
    output logic        group_end,
    output logic [1:0]  seg
);

    state_t      state_reg;
    blk_t        blk_reg;
    logic [1:0]  seg_reg;
    logic [1:0]  load_step_reg;
    logic [3:0]  crc_idx_reg;
    logic [4:0]  bit_cnt_reg;
    logic [15:0] data_reg;
    logic [25:0] shreg_reg;
    logic        pending_reg;
    logic [4:0]  pty_lat_reg;
    logic        tp_lat_reg;
    logic        ta_lat_reg;
    logic        ms_lat_reg;
    logic [2:0]  ps_addr_reg;
    logic        bit_out_reg;
    logic        bit_valid_reg;
    logic        group_end_reg;

    logic        crc_start;
    logic        crc_din;
    logic        crc_busy;
    logic [9:0]  crc_val;
    logic        serve;
    logic        fold_ck;
    logic [15:0] blk_b_word;
    logic [25:0] send_word;

    assign crc_start = (state_reg == CRC) && (crc_idx_reg == 4'd0);
    assign crc_din   = data_reg[4'd15 - crc_idx_reg];

    rds_crc10 u_crc (
        .clk   (clk),
        .reset (reset),
        .start (crc_start),
        .din   (crc_din),
        .busy  (crc_busy),
        .crc   (crc_val)
    );

    assign blk_b_word = {5'b00000, tp_lat_reg, pty_lat_reg, ta_lat_reg, ms_lat_reg,
                         DI_BITS[2'd3 - seg_reg], seg_reg};

    // The checkword lands one cycle after the last data bit; until the first bit of the
    // block leaves, the low 10 bits are taken straight from the generator.
    assign fold_ck   = (bit_cnt_reg == 5'd0) && !crc_busy;
    assign send_word = fold_ck ? {shreg_reg[25:10], crc_val ^ block_offset(blk_reg)}
                               : shreg_reg;
    assign serve     = (state_reg == SEND) && (bit_req || pending_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= LOAD;
            blk_reg       <= BLK_A;
            seg_reg       <= 2'd0;
            load_step_reg <= 2'd0;
            crc_idx_reg   <= 4'd0;
            bit_cnt_reg   <= 5'd0;
            data_reg      <= 16'd0;
            shreg_reg     <= 26'd0;
            pending_reg   <= 1'b0;
            pty_lat_reg   <= 5'd0;
            tp_lat_reg    <= 1'b0;
            ta_lat_reg    <= 1'b0;
            ms_lat_reg    <= 1'b0;
            ps_addr_reg   <= 3'd0;
            bit_out_reg   <= 1'b0;
            bit_valid_reg <= 1'b0;
            group_end_reg <= 1'b0;
        end else begin
            group_end_reg <= 1'b0;
            case (state_reg)
                LOAD: begin
                    if (bit_req) pending_reg <= 1'b1;
                    crc_idx_reg <= 4'd0;
                    case (blk_reg)
                        BLK_A: begin
                            data_reg    <= pi;
                            pty_lat_reg <= pty;
                            tp_lat_reg  <= tp;
                            ta_lat_reg  <= ta;
                            ms_lat_reg  <= ms;
                            state_reg   <= CRC;
                        end
                        BLK_B: begin
                            data_reg  <= blk_b_word;
                            state_reg <= CRC;
                        end
                        BLK_C: begin
                            data_reg  <= AF_WORD;
                            state_reg <= CRC;
                        end
                        default: begin
                            // ps_addr already points at 2*seg on entry (set at the end of C).
                            case (load_step_reg)
                                2'd0: begin
                                    ps_addr_reg   <= {seg_reg, 1'b1};
                                    load_step_reg <= 2'd1;
                                end
                                2'd1: begin
                                    data_reg[15:8] <= ps_data;
                                    load_step_reg  <= 2'd2;
                                end
                                default: begin
                                    data_reg[7:0] <= ps_data;
                                    load_step_reg <= 2'd0;
                                    state_reg     <= CRC;
                                end
                            endcase
                        end
                    endcase
                end
                CRC: begin
                    if (bit_req) pending_reg <= 1'b1;
                    crc_idx_reg <= crc_idx_reg + 4'd1;
                    if (crc_idx_reg == 4'(DATA_BITS - 1)) begin
                        state_reg   <= SEND;
                        shreg_reg   <= {data_reg, 10'd0};
                        bit_cnt_reg <= 5'd0;
                    end
                end
                SEND: begin
                    if (serve) begin
                        bit_out_reg   <= send_word[25];
                        bit_valid_reg <= 1'b1;
                        shreg_reg     <= {send_word[24:0], 1'b0};
                        pending_reg   <= 1'b0;
                        bit_cnt_reg   <= bit_cnt_reg + 5'd1;
                        if (bit_cnt_reg == 5'(BLOCK_BITS - 1)) begin
                            state_reg <= LOAD;
                            blk_reg   <= blk_t'(blk_reg + 2'd1);
                            if (blk_reg == BLK_C) ps_addr_reg <= {seg_reg, 1'b0};
                            if (blk_reg == BLK_D) begin
                                group_end_reg <= 1'b1;
                                seg_reg       <= seg_reg + 2'd1;
                            end
                        end
                    end else begin
                        shreg_reg <= send_word;
                    end
                end
                default: state_reg <= LOAD;
            endcase
        end
    end

    assign ps_addr   = ps_addr_reg;
    assign bit_out   = bit_out_reg;
    assign bit_valid = bit_valid_reg;
    assign group_end = group_end_reg;
    assign seg       = seg_reg;

endmodule

// File: tb/tb_rds_group_encoder.sv
// Directed bench for rds_group_encoder: pulls bits with widely spaced bit_req strobes and
// compares whole blocks against reference RDS groups built in the bench.
module tb_rds_group_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pi;
    logic [4:0]  pty;
    logic        tp, ta, ms;
    logic [2:0]  ps_addr;
    logic [7:0]  ps_data;
    logic        bit_req;
    logic        bit_out, bit_valid, group_end;
    logic [1:0]  seg;

    logic [7:0]  ps_mem [0:7];
    logic [15:0] d_ref [4] = '{16'h5241, 16'h4449, 16'h4F20, 16'h5A47};
    logic [2:0]  b_ref [4] = '{3'b000, 3'b001, 3'b010, 3'b111};

    int errors = 0;
    int checks = 0;
    int ge_cnt = 0;

    localparam int GAP = 22;

    rds_group_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .pi        (pi),
        .pty       (pty),
        .tp        (tp),
        .ta        (ta),
        .ms        (ms),
        .ps_addr   (ps_addr),
        .ps_data   (ps_data),
        .bit_req   (bit_req),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .group_end (group_end),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ps_data <= ps_mem[ps_addr];

    always @(negedge clk) if (group_end) ge_cnt <= ge_cnt + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checkword by long division of data*x^10 by g(x), then offset.
    function automatic logic [25:0] mk_block(input logic [15:0] d, input logic [9:0] off);
        logic [25:0] r;
        r = {d, 10'd0};
        for (int i = 25; i >= 10; i--)
            if (r[i]) r = r ^ (26'(11'h5B9) << (i - 10));
        return {d, r[9:0] ^ off};
    endfunction

    function automatic logic [103:0] exp_group(input logic [15:0] p, input logic [1:0] s);
        logic [3:0]  di;
        logic [15:0] bw, dw;
        di = 4'b0001;
        bw = {5'b00000, tp, pty, ta, ms, di[3 - s], s};
        dw = {ps_mem[{s, 1'b0}], ps_mem[{s, 1'b1}]};
        return {mk_block(p, 10'h0FC), mk_block(bw, 10'h198),
                mk_block(16'hE0CD, 10'h168), mk_block(dw, 10'h1B4)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic get_bit(output logic b);
        @(negedge clk);
        bit_req = 1'b1;
        @(negedge clk);
        bit_req = 1'b0;
        repeat (GAP) @(negedge clk);
        b = bit_out;
    endtask

    task automatic get_bits(input int n, inout logic [103:0] v);
        logic b;
        for (int i = 0; i < n; i++) begin
            get_bit(b);
            v = {v[102:0], b};
        end
    endtask

    task automatic get_group(input string tag, input logic [1:0] s, input int skip,
                             input logic [103:0] pre, output logic [103:0] g);
        int   ge0;
        logic b;
        g   = pre;
        ge0 = ge_cnt;
        chk({tag, ".seg"}, 32'(seg), 32'(s));
        for (int i = skip; i < 104; i++) begin
            get_bit(b);
            g = {g[102:0], b};
            if (i == 102) chk({tag, ".end_early"}, 32'(ge_cnt - ge0), 32'd0);
        end
        chk({tag, ".group_end"}, 32'(ge_cnt - ge0), 32'd1);
        chk({tag, ".seg_next"}, 32'(seg), 32'(2'(s + 2'd1)));
    endtask

    task automatic chk_group(input string tag, input logic [103:0] g, input logic [103:0] e);
        chk({tag, ".A"}, 32'(g[103:78]), 32'(e[103:78]));
        chk({tag, ".B"}, 32'(g[77:52]),  32'(e[77:52]));
        chk({tag, ".C"}, 32'(g[51:26]),  32'(e[51:26]));
        chk({tag, ".D"}, 32'(g[25:0]),   32'(e[25:0]));
    endtask

    initial begin
        logic [103:0] g, e;
        logic [63:0]  ps_name;
        logic         b;

        pi = 16'h0000; pty = 5'd0; tp = 1'b0; ta = 1'b0; ms = 1'b0; bit_req = 1'b0;
        ps_name = "RADIO ZG";
        for (int i = 0; i < 8; i++) ps_mem[i] = ps_name[63 - 8*i -: 8];

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst.bit_out",   32'(bit_out),   32'd0);
        chk("rst.bit_valid", 32'(bit_valid), 32'd0);
        chk("rst.group_end", 32'(group_end), 32'd0);
        chk("rst.seg",       32'(seg),       32'd0);
        chk("rst.ps_addr",   32'(ps_addr),   32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1: pi=0 -> checkword is the bare offset
        g = '0;
        get_bits(26, g);
        chk("t1.blockA", 32'(g[25:0]), 32'({16'h0000, 10'h0FC}));
        chk("t1.valid",  32'(bit_valid), 32'd1);

        // 2: pi=1 -> 1B9 ^ 0FC
        pi = 16'h0001;
        do_reset();
        g = '0;
        get_bits(26, g);
        chk("t2.blockA", 32'(g[25:0]), 32'({16'h0001, 10'h145}));

        // 3: four full groups of "RADIO ZG"
        pi = 16'h2F3A; tp = 1'b1; pty = 5'd10;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            get_group($sformatf("t3.g%0d", s), 2'(s), 0, '0, g);
            e = exp_group(pi, 2'(s));
            chk_group($sformatf("t3.g%0d", s), g, e);
            chk($sformatf("t3.g%0d.Dword", s), 32'(g[25:10]), 32'(d_ref[s]));
            chk($sformatf("t3.g%0d.Bdiseg", s), 32'(g[64:62]), 32'(b_ref[s]));
        end

        // 4: strobes during CRC of block A; the second one is dropped
        pi = 16'hC3A5;
        do_reset();
        repeat (3) @(negedge clk);
        bit_req = 1'b1;
        @(negedge clk);
        bit_req = 1'b0;
        repeat (2) @(negedge clk);
        bit_req = 1'b1;
        @(negedge clk);
        bit_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4.valid_early", 32'(bit_valid), 32'd0);
        repeat (25) @(negedge clk);
        b = bit_out;
        chk("t4.first_bit", 32'(b), 32'(pi[15]));
        chk("t4.valid", 32'(bit_valid), 32'd1);
        get_group("t4", 2'd0, 1, {103'd0, b}, g);
        chk_group("t4", g, exp_group(pi, 2'd0));

        // 5: asynchronous reset at bit 60 of the second group
        do_reset();
        get_group("t5.g0", 2'd0, 0, '0, g);
        chk_group("t5.g0", g, exp_group(pi, 2'd0));
        g = '0;
        get_bits(60, g);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t5.async.valid",   32'(bit_valid), 32'd0);
        chk("t5.async.seg",     32'(seg),       32'd0);
        chk("t5.async.bit_out", 32'(bit_out),   32'd0);
        chk("t5.async.ps_addr", 32'(ps_addr),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        get_group("t5.g1", 2'd0, 0, '0, g);
        chk_group("t5.g1", g, exp_group(pi, 2'd0));

        // 6: pi changes during block C
        pi = 16'h1234;
        do_reset();
        g = '0;
        get_bits(60, g);
        pi = 16'hBEEF;
        get_group("t6.g0", 2'd0, 60, g, g);
        chk_group("t6.g0", g, exp_group(16'h1234, 2'd0));
        get_group("t6.g1", 2'd1, 0, '0, g);
        chk_group("t6.g1", g, exp_group(16'hBEEF, 2'd1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
